msrh_inst_buffer: RTL
=====================

MSRH_INST_BUFFER -- requirements
Module: msrh_inst_buffer

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, meaning instruction slots delivered per fetch beat.
REQ-002 SHALL have parameter DISP_SIZE, default msrh_conf_pkg::DISP_SIZE, meaning instruction slots per dispatch group.
REQ-003 SHALL have parameter DEPTH, default 8, meaning buffer entries (power of two, DEPTH >= FETCH_WIDTH + DISP_SIZE).
REQ-004 SHALL have parameter PC_W, default 39, meaning instruction address width.
REQ-005 i_clk  input  1  clock; all state updates on its rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_flush  input  1  discards all buffered and incoming instructions.
REQ-008 i_f_valid  input  1  fetch beat valid.
REQ-009 o_f_ready  output  1  buffer can accept a full fetch beat.
REQ-010 i_f_pc  input  PC_W  address of fetch slot 0.
REQ-011 i_f_inst  input  FETCH_WIDTH*32  instruction words, slot k at bits [32k+31:32k].
REQ-012 i_f_mask  input  FETCH_WIDTH  per-slot valid, contiguous from slot 0.
REQ-013 o_disp_valid  output  1  dispatch group valid.
REQ-014 i_disp_ready  input  1  downstream decoder accepts the group.
REQ-015 o_disp_pc_addr  output  PC_W  address of oldest instruction in group.
REQ-016 o_disp_inst  output  DISP_SIZE*32  group instructions, slot 0 oldest.
REQ-017 o_disp_inst_valid  output  DISP_SIZE  per-slot valid, contiguous from slot 0.

Function
REQ-018 SHALL store per entry: 32-bit instruction, PC_W-bit address.
REQ-019 SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0, plus count of log2(DEPTH)+1 bits.
REQ-020 o_f_ready SHALL be 1 iff (DEPTH - count) >= FETCH_WIDTH, from registered state only (no dependence on i_disp_ready).
REQ-021 Fetch beat accepted when i_f_valid & o_f_ready & !i_flush; slots with i_f_mask[k]=1 written at tail+k (mod DEPTH), address i_f_pc + 4*k; tail advances by popcount(i_f_mask).
REQ-022 Accepted beat with i_f_mask = 0 SHALL change no state.
REQ-023 Written instruction SHALL first appear on dispatch outputs the cycle after acceptance (1-cycle latency); no bypass.
REQ-024 o_disp_valid SHALL be 1 iff count > 0 and no flush is in effect.
REQ-025 Group size n = min(count, DISP_SIZE); o_disp_inst slot j = entry head+j for j < n; o_disp_inst_valid[j] = (j < n); slots j >= n SHALL drive 0.
REQ-026 o_disp_pc_addr SHALL equal address of entry head when o_disp_valid; 0 otherwise.
REQ-027 Group dispatched when o_disp_valid & i_disp_ready; head advances by n.
REQ-028 While o_disp_valid & !i_disp_ready, all dispatch outputs SHALL hold stable except that new entries may extend the group when n < DISP_SIZE.
REQ-029 Simultaneous enqueue and dequeue: count_next = count + popcount(i_f_mask) - n; enqueue may fill entries freed in the same cycle only in the following cycle.
REQ-030 i_flush = 1: next cycle head = tail = 0, count = 0; same-cycle fetch beat and dispatch handshake ignored; o_disp_valid SHALL be 0 in the flush cycle.
REQ-031 Count SHALL never exceed DEPTH nor underflow; assertions required.

Reset
REQ-032 On i_reset_n low, asynchronously: head = tail = 0, count = 0, o_disp_valid = 0, o_disp_inst_valid = 0, o_disp_pc_addr = 0, o_f_ready = 1.
REQ-033 Entry storage need not be reset; outputs SHALL be gated by valid so stale data is never visible.
REQ-034 Reset asserted mid-operation SHALL discard all contents identically to REQ-032; first fetch after deassertion lands at entry 0.

Verification
REQ-035 Reset release, single beat pc=0x1000 mask=11 inst A,B, ready=1 -> next cycle valid=1, pc=0x1000, inst_valid=11, {A,B}; after handshake count=0.
REQ-036 Five beats mask=11, i_disp_ready=0 -> o_f_ready drops to 0 once count=8 (after 4 beats); fifth beat not accepted; count stays 8.
REQ-037 Beat mask=01 pc=0x2000 -> group n=1, inst_valid=01, slot 1 = 0, pc=0x2000; next beat mask=11 pc=0x2004 fills entries 1,2 in order.
REQ-038 Continuous enqueue/dequeue for 20 beats -> pointers wrap past 7 -> 0, dispatched order and addresses match fetch order exactly, no loss or duplication.
REQ-039 Count=6, i_flush=1 with i_f_valid=1 and i_disp_ready=1 -> o_disp_valid=0 that cycle; next cycle count=0, o_f_ready=1, beat discarded.
REQ-040 Reset asserted with count=5 -> outputs immediately go to REQ-032 values; after release, first beat appears at pc given, no stale entries.

Source files
------------

// File: rtl/msrh_inst_buffer.sv
// Instruction buffer between fetch and decode. A circular FIFO accepts
// FETCH_WIDTH-wide fetch beats and hands out DISP_SIZE-wide dispatch groups,
// oldest first.

package msrh_conf_pkg;
    parameter int DISP_SIZE = 2;
endpackage

// One dispatch lane: forces the word to zero when the lane is not in the group
module msrh_ib_disp_slot (
    input  logic        i_vld,
    input  logic [31:0] i_inst,
    output logic        o_vld,
    output logic [31:0] o_inst
);
    assign o_vld  = i_vld;
    assign o_inst = i_vld ? i_inst : 32'h0;
endmodule

module msrh_inst_buffer #(
    parameter int FETCH_WIDTH = 2,
    parameter int DISP_SIZE   = msrh_conf_pkg::DISP_SIZE,
    parameter int DEPTH       = 8,
    parameter int PC_W        = 39
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic                     i_f_valid,
    output logic                     o_f_ready,
    input  logic [PC_W-1:0]          i_f_pc,
    input  logic [FETCH_WIDTH*32-1:0] i_f_inst,
    input  logic [FETCH_WIDTH-1:0]   i_f_mask,
    output logic                     o_disp_valid,
    input  logic                     i_disp_ready,
    output logic [PC_W-1:0]          o_disp_pc_addr,
    output logic [DISP_SIZE*32-1:0]  o_disp_inst,
    output logic [DISP_SIZE-1:0]     o_disp_inst_valid
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] FW_C    = (AW+1)'(FETCH_WIDTH);
    localparam logic [AW:0] DS_C    = (AW+1)'(DISP_SIZE);

    logic [31:0]     mem_inst [DEPTH];
    logic [PC_W-1:0] mem_pc   [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic [AW:0]     push_n;
    logic [AW:0]     grp_n;
    logic [AW:0]     pop_n;

    // Ready looks only at registered occupancy, so freed slots are reusable
    // one cycle after the dequeue that frees them.
    assign o_f_ready    = (DEPTH_C - count) >= FW_C;
    assign push         = i_f_valid & o_f_ready & ~i_flush;
    assign o_disp_valid = (count != '0) & ~i_flush;
    assign pop          = o_disp_valid & i_disp_ready;
    assign grp_n        = (count < DS_C) ? count : DS_C;
    assign pop_n        = pop ? grp_n : '0;

    // Number of slots written by this beat (zero when the beat is not taken)
    always_comb begin
        push_n = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            push_n = push_n + (AW+1)'(i_f_mask[k] & push);
    end

    // Head/tail/count; flush wins over any same-cycle handshake
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + push_n - pop_n;
        end
    end

    // Entry storage: no reset, visibility is gated by count
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (push && i_f_mask[k]) begin
                mem_inst[tail + AW'(k)] <= i_f_inst[32*k +: 32];
                mem_pc[tail + AW'(k)]   <= i_f_pc + PC_W'(4*k);
            end
        end
    end

    // Dispatch lanes read straight from storage at head+j
    for (genvar j = 0; j < DISP_SIZE; j++) begin : g_slot
        logic [AW-1:0] idx;
        logic          lane_vld;
        assign idx      = head + AW'(j);
        assign lane_vld = o_disp_valid & ((AW+1)'(j) < grp_n);
        msrh_ib_disp_slot u_slot (
            .i_vld  (lane_vld),
            .i_inst (mem_inst[idx]),
            .o_vld  (o_disp_inst_valid[j]),
            .o_inst (o_disp_inst[32*j +: 32])
        );
    end

    assign o_disp_pc_addr = o_disp_valid ? mem_pc[head] : '0;

    // Occupancy must stay within [0, DEPTH]
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (count <= DEPTH_C)
                else $error("inst buffer count above depth");
            assert (pop_n <= count)
                else $error("inst buffer underflow");
            assert (int'(count) + int'(push_n) <= DEPTH + int'(pop_n))
                else $error("inst buffer overflow");
        end
    end
endmodule
